// File: rtl/zhang_cnn_requant_acc.sv
// Window accumulator and requantizer: sums signed 32-bit products per window,
// then scale, rounding shift, zero-point add and saturation to OUT_WIDTH.
// Ports: ap_clk/ap_rst_n; prod_* input stream (tdata/tvalid/tlast/tready);
// scale/shift/zero_point sampled on tlast; out_* output stream; sat_cnt.
// Option: define ZHANG_CNN_REQUANT_RELU_EN to clamp results below zero_point.
module zhang_cnn_requant_acc #(
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [31:0]          prod_tdata,
  input  logic                 prod_tvalid,
  input  logic                 prod_tlast,
  output logic                 prod_tready,
  input  logic [15:0]          scale,
  input  logic [5:0]           shift,
  input  logic [15:0]          zero_point,
  output logic [OUT_WIDTH-1:0] out_tdata,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic [15:0]          sat_cnt
);

  localparam int PW = ACC_WIDTH + 16;
  localparam int RW = PW + 2;
  localparam logic signed [RW-1:0] MAXV =
    (RW'(1) <<< (OUT_WIDTH - 1)) - RW'(1);
  localparam logic signed [RW-1:0] MINV = -MAXV - RW'(1);

  logic [ACC_WIDTH-1:0]        r_acc;
  logic                        r_s1_valid;
  logic signed [PW-1:0]        r_s1_p;
  logic [5:0]                  r_s1_sh;
  logic [15:0]                 r_s1_zp;
  logic [OUT_WIDTH-1:0]        r_out;
  logic                        r_out_valid;
  logic [15:0]                 r_sat;

  logic                        w_stall;
  logic                        w_ready;
  logic                        w_fire;
  logic [ACC_WIDTH-1:0]        w_sum;
  logic signed [PW-1:0]        w_p;
  logic [5:0]                  w_sh;
  logic signed [RW-1:0]        w_p_ext;
  logic signed [RW-1:0]        w_bias;
  logic signed [RW-1:0]        w_rnd;
  logic signed [RW-1:0]        w_zp_ext;
  logic signed [RW-1:0]        w_v;
  logic                        w_hi;
  logic                        w_lo;
  logic [OUT_WIDTH-1:0]        w_sat;
  logic [OUT_WIDTH-1:0]        w_res;
  logic                        w_clip;

  assign w_stall = r_out_valid && !out_tready;
  // S1 may load whenever it is empty or moving forward into S2.
  assign w_ready = !(r_s1_valid && w_stall);
  assign w_fire  = prod_tvalid && w_ready;

  assign w_sum = r_acc + {{(ACC_WIDTH-32){prod_tdata[31]}}, prod_tdata};
  assign w_p   = $signed({{16{w_sum[ACC_WIDTH-1]}}, w_sum})
               * $signed({{ACC_WIDTH{scale[15]}}, scale});
  assign w_sh  = (shift > 6'd47) ? 6'd47 : shift;

  always_comb begin
    w_p_ext  = {{2{r_s1_p[PW-1]}}, r_s1_p};
    w_bias   = '0;
    if (r_s1_sh != 6'd0)
      w_bias = RW'(1) << (r_s1_sh - 6'd1);
    // Adding half an LSB before the arithmetic shift rounds half toward +inf.
    w_rnd    = (w_p_ext + w_bias) >>> r_s1_sh;
    w_zp_ext = {{(RW-16){r_s1_zp[15]}}, r_s1_zp};
    w_v      = w_rnd + w_zp_ext;
    w_hi     = w_v > MAXV;
    w_lo     = w_v < MINV;
    w_sat    = w_v[OUT_WIDTH-1:0];
    if (w_hi)
      w_sat = MAXV[OUT_WIDTH-1:0];
    else if (w_lo)
      w_sat = MINV[OUT_WIDTH-1:0];
    w_res    = w_sat;
    w_clip   = w_hi || w_lo;
`ifdef ZHANG_CNN_REQUANT_RELU_EN
    if ($signed({{(RW-OUT_WIDTH){w_sat[OUT_WIDTH-1]}}, w_sat}) < w_zp_ext) begin
      w_res  = w_zp_ext[OUT_WIDTH-1:0];
      w_clip = w_hi;
    end
`endif
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_acc       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_p      <= '0;
      r_s1_sh     <= '0;
      r_s1_zp     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_sat       <= '0;
    end else begin
      if (w_fire)
        r_acc <= prod_tlast ? '0 : w_sum;
      if (w_ready) begin
        r_s1_valid <= w_fire && prod_tlast;
        if (w_fire && prod_tlast) begin
          r_s1_p  <= w_p;
          r_s1_sh <= w_sh;
          r_s1_zp <= zero_point;
        end
      end
      if (!w_stall) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out <= w_res;
          if (w_clip && r_sat != 16'hFFFF)
            r_sat <= r_sat + 16'd1;
        end
      end
    end
  end

  assign prod_tready = w_ready;
  assign out_tdata   = r_out;
  assign out_tvalid  = r_out_valid;
  assign sat_cnt     = r_sat;

endmodule

// File: tb/tb_zhang_cnn_requant_acc.sv
// Scoreboard bench for zhang_cnn_requant_acc: directed windows push expected
// outputs into a queue; a monitor pops and compares on each output transfer.
module tb_zhang_cnn_requant_acc;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [31:0] prod_tdata;
  logic        prod_tvalid;
  logic        prod_tlast;
  logic        prod_tready;
  logic [15:0] scale;
  logic [5:0]  shift;
  logic [15:0] zero_point;
  logic [15:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic [15:0] sat_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];

  zhang_cnn_requant_acc dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .prod_tdata(prod_tdata), .prod_tvalid(prod_tvalid),
    .prod_tlast(prod_tlast), .prod_tready(prod_tready),
    .scale(scale), .shift(shift), .zero_point(zero_point),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .sat_cnt(sat_cnt)
  );

  always #5 ap_clk = ~ap_clk;
  always @(negedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int relu(input int v, input int zp);
`ifdef ZHANG_CNN_REQUANT_RELU_EN
    return (v < zp) ? zp : v;
`else
    return v + 0 * zp;
`endif
  endfunction

  always @(negedge ap_clk) begin
    if (ap_rst_n && out_tvalid && out_tready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got %0d expected none",
                 $signed(out_tdata));
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (out_tdata !== e) begin
          bad++;
          $display("FAIL out_data: got %0d expected %0d",
                   $signed(out_tdata), $signed(e));
        end
      end
    end
  end

  // Called right after a posedge; returns at the accepting posedge.
  task automatic send(input logic [31:0] d, input bit last,
                      input logic [15:0] sc, input logic [5:0] sh,
                      input logic [15:0] zp, input int ev);
    int n;
    if (last) exp_q.push_back(16'(ev));
    #1;
    prod_tdata  = d;
    prod_tlast  = last;
    prod_tvalid = 1'b1;
    scale       = sc;
    shift       = sh;
    zero_point  = zp;
    n = 0;
    forever begin
      @(negedge ap_clk);
      if (prod_tready) begin
        @(posedge ap_clk);
        break;
      end
      @(posedge ap_clk);
      n++;
      if (n > 200) begin
        chk("send_timeout", n, 0);
        break;
      end
    end
  endtask

  task automatic idle();
    #1;
    prod_tvalid = 1'b0;
    prod_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", exp_q.size(), 0);
    @(posedge ap_clk);
  endtask

  initial begin
    int c0;
    ap_rst_n    = 1'b0;
    prod_tdata  = '0;
    prod_tvalid = 1'b0;
    prod_tlast  = 1'b0;
    scale       = '0;
    shift       = '0;
    zero_point  = '0;
    out_tready  = 1'b1;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_tready", int'(prod_tready), 1);
    chk("rst_tvalid", int'(out_tvalid), 0);
    chk("rst_tdata", int'(out_tdata), 0);
    chk("rst_sat", int'(sat_cnt), 0);
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(posedge ap_clk);

    // basic window with latency check
    send(32'd100, 0, 16'd2, 6'd1, 16'd0, 0);
    send(32'd200, 0, 16'd2, 6'd1, 16'd0, 0);
    send(-32'sd50, 1, 16'd2, 6'd1, 16'd0, 250);
    idle();
    @(negedge ap_clk);
    chk("lat_t1_valid", int'(out_tvalid), 0);
    @(negedge ap_clk);
    chk("lat_t2_valid", int'(out_tvalid), 1);
    drain();
    chk("basic_sat", int'(sat_cnt), 0);

    // rounding half toward +inf
    send(-32'sd3, 1, 16'd1, 6'd1, 16'd0, relu(-1, 0));
    send(32'd5, 1, 16'd1, 6'd1, 16'd0, 3);
    idle();
    drain();

    // saturation
    send(32'h7FFF0000, 1, 16'd1, 6'd0, 16'd0, 32767);
    idle();
    drain();
    chk("sat_hi_cnt", int'(sat_cnt), 1);
    send(32'h80000000, 1, 16'd1, 6'd0, 16'd0, relu(-32768, 0));
    idle();
    drain();
`ifdef ZHANG_CNN_REQUANT_RELU_EN
    chk("sat_lo_cnt", int'(sat_cnt), 1);
`else
    chk("sat_lo_cnt", int'(sat_cnt), 2);
`endif

    // zero-point offset (ReLU case)
    send(-32'sd100, 1, 16'd1, 6'd0, 16'd5, relu(-95, 5));
    idle();
    drain();

    // throughput with mixed parameters, incl. negative scale and shift clamp
    c0 = cyc;
    send(32'd10, 1, 16'd1, 6'd0, 16'd0, 10);
    send(32'd3, 1, 16'd1, 6'd1, 16'd0, 2);
    send(-32'sd1, 1, 16'd1, 6'd1, 16'd0, 0);
    send(32'd1000, 1, -16'sd3, 6'd2, 16'd10, relu(-740, 10));
    send(32'h40000000, 1, 16'd16384, 6'd63, 16'd0, 0);
    chk("thruput_cycles", cyc - c0, 5);
    idle();
    drain();

    // backpressure
    #1 out_tready = 1'b0;
    @(posedge ap_clk);
    send(32'd1, 1, 16'd1, 6'd0, 16'd0, 1);
    send(32'd2, 1, 16'd1, 6'd0, 16'd0, 2);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      chk("bp_tready", int'(prod_tready), 0);
      chk("bp_valid", int'(out_tvalid), 1);
      chk("bp_hold", int'(out_tdata), 1);
    end
    @(posedge ap_clk);
    #1 out_tready = 1'b1;
    @(posedge ap_clk);
    send(32'd3, 1, 16'd1, 6'd0, 16'd0, 3);
    send(32'd4, 1, 16'd1, 6'd0, 16'd0, 4);
    idle();
    drain();

    // reset mid-window
    send(32'd1000, 0, 16'd1, 6'd0, 16'd0, 0);
    send(32'd1000, 0, 16'd1, 6'd0, 16'd0, 0);
    idle();
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b0;
    @(negedge ap_clk);
    chk("mid_rst_tready", int'(prod_tready), 1);
    chk("mid_rst_tvalid", int'(out_tvalid), 0);
    chk("mid_rst_tdata", int'(out_tdata), 0);
    chk("mid_rst_sat", int'(sat_cnt), 0);
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    send(32'd7, 1, 16'd1, 6'd0, 16'd0, 7);
    idle();
    drain();

    repeat (3) @(posedge ap_clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
